// File: rtl/mod_segment_seq.sv
// rtl/mod_segment_seq.sv - per-symbol segment sequencer selecting reference or mirrored table
//
// Accepts one symbol word per input handshake and compares it with zero.
// It then streams NUM_SEG registered segments from array_ref_wire (equal)
// or array_ref_m_wire (not equal). Back-to-back symbols are accepted on the
// last segment's transfer, so there is no bubble between them.
//
// Optional feature: define MOD_SEG_STATS_EN to add the sym_count / mism_count outputs.
//
// Ports:
//   clk              in   rising-edge clock
//   reset            in   asynchronous active-low reset
//   in_valid         in   symbol valid
//   in_ready         out  symbol can be accepted this cycle (combinational)
//   input_bit        in   symbol word
//   zero             in   comparison word, sampled with input_bit
//   array_ref_wire   in   reference segments, segment k at [k*DATA_W +: DATA_W]
//   array_ref_m_wire in   mirrored reference segments, same packing
//   out_valid        out  segment_out valid
//   out_ready        in   downstream accepts segment
//   segment_out      out  current segment word
//   seg_idx          out  index of segment_out within its symbol
//   last_seg         out  final segment of the symbol is presented
//   sym_count        out  accepted symbols (MOD_SEG_STATS_EN only)
//   mism_count       out  accepted mismatch symbols (MOD_SEG_STATS_EN only)

module mod_segment_seq #(
  parameter int DATA_W    = 32,
  parameter int NUM_SEG   = 8,
  parameter int SEG_IDX_W = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         input_bit,
  input  logic [DATA_W-1:0]         zero,
  input  logic [NUM_SEG*DATA_W-1:0] array_ref_wire,
  input  logic [NUM_SEG*DATA_W-1:0] array_ref_m_wire,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         segment_out,
  output logic [SEG_IDX_W-1:0]      seg_idx,
  output logic                      last_seg
`ifdef MOD_SEG_STATS_EN
  ,
  output logic [15:0]               sym_count,
  output logic [15:0]               mism_count
`endif
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  localparam logic [SEG_IDX_W-1:0] LAST_IDX = SEG_IDX_W'(NUM_SEG - 1);

  state_t state;
  logic   sel;

  // Tables unpacked into word arrays so the next segment can be indexed directly.
  logic [DATA_W-1:0] ref_seg   [NUM_SEG];
  logic [DATA_W-1:0] ref_m_seg [NUM_SEG];

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_unpack
    assign ref_seg[k]   = array_ref_wire[k*DATA_W +: DATA_W];
    assign ref_m_seg[k] = array_ref_m_wire[k*DATA_W +: DATA_W];
  end

  logic                 load_sel;
  logic [DATA_W-1:0]    first_word;
  logic [SEG_IDX_W-1:0] next_idx;
  logic [DATA_W-1:0]    next_word;

  always_comb begin
    load_sel   = (input_bit != zero);
    first_word = load_sel ? ref_m_seg[0] : ref_seg[0];
    next_idx   = seg_idx + 1'b1;
    // Only used while seg_idx < NUM_SEG-1, so next_idx stays in range.
    next_word  = sel ? ref_m_seg[next_idx] : ref_seg[next_idx];
  end

  assign last_seg = out_valid && (seg_idx == LAST_IDX);
  assign in_ready = (state == IDLE) || (last_seg && out_ready);

  logic accept;
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      segment_out <= '0;
      seg_idx     <= '0;
      sel         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sel         <= load_sel;
            segment_out <= first_word;
            seg_idx     <= '0;
            out_valid   <= 1'b1;
            state       <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (seg_idx != LAST_IDX) begin
              seg_idx     <= next_idx;
              segment_out <= next_word;
            end else if (in_valid) begin
              // Final segment leaves while the next symbol is loaded: no bubble.
              sel         <= load_sel;
              segment_out <= first_word;
              seg_idx     <= '0;
            end else begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef MOD_SEG_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sym_count  <= '0;
      mism_count <= '0;
    end else if (accept) begin
      sym_count <= sym_count + 16'd1;
      if (load_sel) begin
        mism_count <= mism_count + 16'd1;
      end
    end
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_mod_segment_seq.sv
// tb/tb_mod_segment_seq.sv - scoreboard bench for mod_segment_seq

module tb_mod_segment_seq;

  localparam int DATA_W    = 32;
  localparam int NUM_SEG   = 8;
  localparam int SEG_IDX_W = 3;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         input_bit;
  logic [DATA_W-1:0]         zero;
  logic [NUM_SEG*DATA_W-1:0] array_ref_wire;
  logic [NUM_SEG*DATA_W-1:0] array_ref_m_wire;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         segment_out;
  logic [SEG_IDX_W-1:0]      seg_idx;
  logic                      last_seg;
`ifdef MOD_SEG_STATS_EN
  logic [15:0]               sym_count;
  logic [15:0]               mism_count;
`endif

  mod_segment_seq #(
    .DATA_W(DATA_W),
    .NUM_SEG(NUM_SEG),
    .SEG_IDX_W(SEG_IDX_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .input_bit(input_bit),
    .zero(zero),
    .array_ref_wire(array_ref_wire),
    .array_ref_m_wire(array_ref_m_wire),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .segment_out(segment_out),
    .seg_idx(seg_idx),
    .last_seg(last_seg)
`ifdef MOD_SEG_STATS_EN
    ,
    .sym_count(sym_count),
    .mism_count(mism_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0]    seg;
    logic [SEG_IDX_W-1:0] idx;
    logic                 last;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected stream for one symbol, built from the bench's own table contents.
  task automatic push_symbol(input bit mism);
    exp_t e;
    for (int k = 0; k < NUM_SEG; k++) begin
      e.seg  = (mism ? 32'h200 : 32'h100) + 32'(k);
      e.idx  = SEG_IDX_W'(k);
      e.last = (k == NUM_SEG - 1);
      sb.push_back(e);
    end
  endtask

  // Drive a symbol, check it is accepted on the next edge, optionally drop in_valid.
  task automatic send(input bit mism, input bit keep_valid);
    input_bit = mism ? 32'h1 : 32'h0;
    zero      = 32'h0;
    in_valid  = 1'b1;
    push_symbol(mism);
    @(negedge clk);
    chk("accept_in_ready", in_ready, 1);
    chk("accept_out_valid_low", out_valid, 0);
    @(posedge clk);
    #1;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  // Consume n segments with out_ready high, each required on consecutive cycles.
  task automatic run_segs(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("seg_out_valid", out_valid, 1);
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("segment_out", segment_out, e.seg);
        chk("seg_idx", seg_idx, e.idx);
        chk("last_seg", last_seg, e.last);
        chk("in_ready_stream", in_ready, e.last && out_ready);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_last_seg"}, last_seg, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    input_bit = '0;
    zero      = '0;
    for (int k = 0; k < NUM_SEG; k++) begin
      array_ref_wire[k*DATA_W +: DATA_W]   = 32'h100 + 32'(k);
      array_ref_m_wire[k*DATA_W +: DATA_W] = 32'h200 + 32'(k);
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_segment_out", segment_out, 0);
    chk("rst_seg_idx", seg_idx, 0);
    chk("rst_last_seg", last_seg, 0);
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_segment_out", segment_out, 0);
      chk("idle_in_ready", in_ready, 1);
    end
    @(posedge clk);
    #1;

    // Match symbol
    send(1'b0, 1'b0);
    run_segs(NUM_SEG);
    expect_idle("after_match");

    // Mismatch symbol
    send(1'b1, 1'b0);
    run_segs(NUM_SEG);
    expect_idle("after_mism");

    // Back-to-back: A (match) then B (mismatch) with in_valid held
    send(1'b0, 1'b1);
    input_bit = 32'h1;
    push_symbol(1'b1);
    run_segs(NUM_SEG);
    in_valid = 1'b0;
    run_segs(NUM_SEG);
    expect_idle("after_b2b");

`ifdef MOD_SEG_STATS_EN
    @(negedge clk);
    chk("sym_count", sym_count, 4);
    chk("mism_count", mism_count, 2);
    @(posedge clk);
    #1;
`endif

    // Backpressure at seg_idx 3
    send(1'b0, 1'b0);
    run_segs(3);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_segment_out", segment_out, 32'h103);
      chk("bp_seg_idx", seg_idx, 3);
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    run_segs(NUM_SEG - 3);
    expect_idle("after_bp");

    // Reset mid-symbol at seg_idx 5
    send(1'b0, 1'b0);
    run_segs(5);
    chk("pre_reset_seg_idx", seg_idx, 5);
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_seg_idx", seg_idx, 0);
    chk("midrst_segment_out", segment_out, 0);
    chk("midrst_last_seg", last_seg, 0);
`ifdef MOD_SEG_STATS_EN
    chk("midrst_sym_count", sym_count, 0);
    chk("midrst_mism_count", mism_count, 0);
`endif
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    expect_idle("after_midrst");
    send(1'b1, 1'b0);
    run_segs(NUM_SEG);
    expect_idle("after_restart");
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
